// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall controller
// Purpose : FSM state type, stage indices into the enable vector, and the
//           enable patterns used by the controller.
// Ports   : none (package)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERROR   = 2'd2
  } fsm_t;

  // Bit positions of each register enable inside the enable vector.
  localparam int NUM_EN     = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_MEM_WB = 4;

  localparam logic [NUM_EN-1:0] EN_ALL    = 5'b11111;
  // Load-use bubble: PC and IF/ID hold, ID/EX onward keep moving.
  localparam logic [NUM_EN-1:0] EN_BUBBLE = 5'b11100;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard inputs and register-control outputs of the stall controller
// Purpose : bundles the datapath-facing signals of pipe_stall_ctrl.
// Ports   : master = datapath side (drives hazard info, receives enables/flushes/status)
//           slave  = controller side (receives hazard info, drives enables/flushes/status)
interface pipe_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_branch_tkn;
  logic                  mem_req;
  logic                  mem_ack;
  logic                  en_pc;
  logic                  en_if_id;
  logic                  en_id_ex;
  logic                  en_ex_mem;
  logic                  en_mem_wb;
  logic                  flush_if_id;
  logic                  flush_id_ex;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_tkn, mem_req, mem_ack,
    input  en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    input  flush_if_id, flush_id_ex, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_mem_read, ex_rd, ex_branch_tkn, mem_req, mem_ack,
    output en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    output flush_if_id, flush_id_ex, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_cmp.sv
// rtl/pipe_hazard_cmp.sv - combinational load-use hazard detector
// Purpose : flags a load in EX whose destination is read by the instruction in ID.
// Ports   : id_rs1, id_rs2 (in)  source registers in ID
//           ex_mem_read (in)     EX instruction is a load
//           ex_rd (in)           EX destination register
//           lu (out)             load-use hazard
module pipe_hazard_cmp #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu
);
  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign lu = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline register enable/flush controller
// Purpose : inserts load-use bubbles, flushes on taken branches, freezes the
//           pipe during data-memory waits and traps a memory timeout.
//           Optional perf counters are built when STALL_PERF_EN is defined.
// Ports   : clk (in)     rising-edge clock
//           arst_n (in)  asynchronous reset, active low
//           bus (slave)  hazard inputs, register enables/flushes, timeout flag,
//                        stall_cnt / flush_cnt
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  pipe_stall_ctrl_if.slave  bus
);

  localparam bit               TIMEOUT_ON  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  fsm_t              state_q, state_d;
  logic              run_q;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic              lu, mf;
  logic [NUM_EN-1:0] issue_en, en_vec;
  logic              issue_fl_if_id, issue_fl_id_ex;
  logic              fl_if_id, fl_id_ex;
  logic              advance;

  pipe_hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_cmp (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .lu          (lu)
  );

  assign mf = bus.mem_req && !bus.mem_ack;

  // Controls for a cycle in which the pipe is allowed to move; a taken
  // branch squashes the load-use victim, so it wins over the bubble.
  always_comb begin
    issue_en       = EN_ALL;
    issue_fl_if_id = 1'b0;
    issue_fl_id_ex = 1'b0;
    if (bus.ex_branch_tkn) begin
      issue_fl_if_id = 1'b1;
      issue_fl_id_ex = 1'b1;
    end else if (lu) begin
      issue_en       = EN_BUBBLE;
      issue_fl_id_ex = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    advance    = 1'b0;
    if (run_q) begin
      case (state_q)
        RUN: begin
          if (mf) begin
            state_d    = MEMWAIT;
            wait_cnt_d = CNT_W'(1);
          end else begin
            advance = 1'b1;
          end
        end
        MEMWAIT: begin
          if (bus.mem_ack) begin
            state_d    = RUN;
            wait_cnt_d = '0;
            advance    = 1'b1;
          end else if (TIMEOUT_ON && (wait_cnt_q == TIMEOUT_LIM)) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        default: ;  // ERROR holds until reset
      endcase
    end
  end

  always_comb begin
    en_vec   = '0;
    fl_if_id = 1'b0;
    fl_id_ex = 1'b0;
    if (advance) begin
      en_vec   = issue_en;
      fl_if_id = issue_fl_if_id;
      fl_id_ex = issue_fl_id_ex;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= RUN;
      run_q      <= 1'b0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.en_pc       = en_vec[STG_PC];
  assign bus.en_if_id    = en_vec[STG_IF_ID];
  assign bus.en_id_ex    = en_vec[STG_ID_EX];
  assign bus.en_ex_mem   = en_vec[STG_EX_MEM];
  assign bus.en_mem_wb   = en_vec[STG_MEM_WB];
  assign bus.flush_if_id = fl_if_id;
  assign bus.flush_id_ex = fl_id_ex;
  assign bus.mem_timeout = timeout_q;

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (run_q && !en_vec[STG_PC] && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (fl_if_id && (flush_q != '1))                 flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  localparam int RW = 5;
  localparam int CW = 16;
  localparam int TO = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  pipe_stall_ctrl #(.REG_ADDR_W(RW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [4:0] en;     // {mem_wb, ex_mem, id_ex, if_id, pc}
    logic [1:0] fl;     // {id_ex, if_id}
    logic       to;
    int         stall;
    int         flc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: plain flags for "pipe started", "waiting on memory",
  // "trapped", plus how many cycles the current access has waited.
  bit m_started, m_waiting, m_trapped, m_flag;
  int m_waited, m_stall, m_flush;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rstn, input logic rd, input logic [RW-1:0] exrd,
                      input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                      input logic br, input logic req, input logic ack);
    exp_t e;
    bit   hazard, moves;
    @(posedge clk);
    #1;
    arst_n            = rstn;
    bus.ex_mem_read   = rd;
    bus.ex_rd         = exrd;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.ex_branch_tkn = br;
    bus.mem_req       = req;
    bus.mem_ack       = ack;
    if (!rstn) begin
      m_started = 0; m_waiting = 0; m_trapped = 0; m_flag = 0;
      m_waited = 0; m_stall = 0; m_flush = 0;
      e = '{en: 5'b0, fl: 2'b0, to: 1'b0, stall: 0, flc: 0};
      sbq.push_back(e);
      return;
    end
    hazard = rd && (exrd != 0) && (exrd == rs1 || exrd == rs2);
    // The pipe moves unless not yet started, trapped, or waiting on memory.
    if (!m_started || m_trapped) moves = 0;
    else if (m_waiting)          moves = ack;
    else                         moves = !(req && !ack);
    e.to = m_flag; e.stall = m_stall; e.flc = m_flush;
    if (!moves)      begin e.en = 5'b00000; e.fl = 2'b00; end
    else if (br)     begin e.en = 5'b11111; e.fl = 2'b11; end
    else if (hazard) begin e.en = 5'b11100; e.fl = 2'b10; end
    else             begin e.en = 5'b11111; e.fl = 2'b00; end
    sbq.push_back(e);
`ifdef STALL_PERF_EN
    if (m_started && !e.en[0] && m_stall < CNT_MAX) m_stall++;
    if (e.fl[0] && m_flush < CNT_MAX)               m_flush++;
`endif
    if (!m_started) m_started = 1;
    else if (m_trapped) ;
    else if (m_waiting) begin
      if (ack) begin m_waiting = 0; m_waited = 0; end
      else if (TO != 0 && m_waited == TO) begin m_trapped = 1; m_flag = 1; m_waiting = 0; end
      else m_waited++;
    end else if (req && !ack) begin
      m_waiting = 1; m_waited = 1;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: outputs are combinational and always presented; sample mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("enables", int'({bus.en_mem_wb, bus.en_ex_mem, bus.en_id_ex, bus.en_if_id, bus.en_pc}), int'(e.en));
        check("flushes", int'({bus.flush_id_ex, bus.flush_if_id}), int'(e.fl));
        check("mem_timeout", int'(bus.mem_timeout), int'(e.to));
        check("stall_cnt", int'(bus.stall_cnt), e.stall);
        check("flush_cnt", int'(bus.flush_cnt), e.flc);
      end
    end
  end

  initial begin
    bit rst_lvl;
    bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.ex_branch_tkn = 0; bus.mem_req = 0; bus.mem_ack = 0;

    // reset and start-up cycle
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();
    // load-use on rs2, then resume
    step(1, 1, 5, 1, 5, 0, 0, 0);
    idle();
    // load to x0 never stalls
    step(1, 1, 0, 0, 0, 0, 0, 0);
    // branch overrides a load-use match
    step(1, 1, 5, 5, 2, 1, 0, 0);
    idle();
    // stray ack with no request is ignored
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // three frozen cycles then ack, with a load-use evaluated on the ack cycle
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 7, 7, 0, 0, 1, 1);
    idle();
    // reset in the middle of a wait
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    idle();
    // timeout: ack never arrives, flag is sticky, late ack ignored
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    idle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst_lvl = !(($urandom % 60 == 0) || (m_trapped && ($urandom % 4 == 0)));
      step(rst_lvl, 1'($urandom % 2), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
           RW'($urandom_range(0, 3)), 1'($urandom % 6 == 0), 1'($urandom % 4 == 0),
           1'($urandom % 3 == 0));
    end

    @(posedge clk);
    @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
